// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shifter: op codes, FSM states and
// the effective iteration count derived from the requested amount.
package shift_pkg;

  localparam int SH_WIDTH = 32;
  localparam int SH_CNT_W = 6;
  localparam int SH_AMT_W = $clog2(SH_WIDTH);

  typedef enum logic [2:0] {
    SHOP_SHR  = 3'b000,
    SHOP_SHRA = 3'b001,
    SHOP_SHL  = 3'b010,
    SHOP_ROR  = 3'b011,
    SHOP_ROL  = 3'b100
  } shop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Rotates wrap modulo the width; plain shifts saturate at the width,
  // which yields 0 (SHR/SHL) or a sign fill (SHRA). Reserved ops do no steps.
  function automatic logic [SH_CNT_W-1:0] eff_count(input logic [2:0] op,
                                                    input logic [SH_WIDTH-1:0] b);
    logic big;
    big = |b[SH_WIDTH-1:SH_AMT_W];
    case (op)
      SHOP_ROR, SHOP_ROL:
        return SH_CNT_W'(b[SH_AMT_W-1:0]);
      SHOP_SHR, SHOP_SHRA, SHOP_SHL:
        return big ? SH_CNT_W'(SH_WIDTH) : SH_CNT_W'(b[SH_AMT_W-1:0]);
      default:
        return '0;
    endcase
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the control unit (master) and the
// shift sequencer (slave).
interface shift_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, op, A, B, input busy, done, result);
  modport slave  (input start, op, A, B, output busy, done, result);
endinterface

// File: rtl/shift_step.sv
// One single-bit shift/rotate step applied to the working register.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = SH_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  shop_e            op,
  output logic [WIDTH-1:0] r_next
);

  always_comb begin
    r_next = r;
    case (op)
      SHOP_SHR:  r_next = {1'b0, r[WIDTH-1:1]};
      SHOP_SHRA: r_next = {r[WIDTH-1], r[WIDTH-1:1]};
      SHOP_SHL:  r_next = {r[WIDTH-2:0], 1'b0};
      SHOP_ROR:  r_next = {r[0], r[WIDTH-1:1]};
      SHOP_ROL:  r_next = {r[WIDTH-2:0], r[WIDTH-1]};
      default:   r_next = r;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Iterative shifter: accepts one op on start, applies one bit step per
// clock while busy, then pulses done with the final value held in result.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = SH_WIDTH,
  parameter int CNT_W = SH_CNT_W
) (
  input  logic              clk,
  input  logic              clr,
  shift_sequencer_if.slave  bus
);

  state_e           state_reg;
  shop_e            op_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] result_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [CNT_W-1:0] start_cnt;
  logic [WIDTH-1:0] step_next;

  assign start_cnt = eff_count(bus.op, bus.B);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .r      (result_reg),
    .op     (op_reg),
    .r_next (step_next)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg  <= ST_IDLE;
      op_reg     <= SHOP_SHR;
      count_reg  <= '0;
      result_reg <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          result_reg <= step_next;
          count_reg  <= count_reg - CNT_W'(1);
          if (count_reg == CNT_W'(1)) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept, so a start held through done chains ops
          if (bus.start) begin
            op_reg     <= shop_e'(bus.op);
            result_reg <= bus.A;
            count_reg  <= start_cnt;
            if (start_cnt != '0) begin
              state_reg <= ST_RUN;
              busy_reg  <= 1'b1;
              done_reg  <= 1'b0;
            end else begin
              state_reg <= ST_DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end
          end else begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.result = result_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: vector table plus hand-written
// sequences for busy re-start, back-to-back accept and mid-run reset.
module tb_shift_sequencer;
  import shift_pkg::*;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(32)) bus ();

  shift_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          n;
  } vec_t;

  vec_t vecs [13];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request and let it be sampled at the next edge.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Count busy cycles from the current cycle until busy falls (bounded).
  task automatic wait_done(output int cyc, output logic overlap);
    cyc = 0;
    overlap = 1'b0;
    while (bus.busy === 1'b1 && cyc < 40) begin
      if (bus.done !== 1'b0) overlap = 1'b1;
      cyc++;
      tick();
    end
  endtask

  initial begin
    int   cyc;
    logic ovl;

    vecs[0]  = '{3'b001, 32'hF000_0000, 32'd4,          32'hFF00_0000, 4};
    vecs[1]  = '{3'b000, 32'h8000_0001, 32'd0,          32'h8000_0001, 0};
    vecs[2]  = '{3'b010, 32'h0000_0001, 32'h0000_0100,  32'h0000_0000, 32};
    vecs[3]  = '{3'b001, 32'h8000_0000, 32'h0000_0100,  32'hFFFF_FFFF, 32};
    vecs[4]  = '{3'b011, 32'h0000_0001, 32'd33,         32'h8000_0000, 1};
    vecs[5]  = '{3'b100, 32'h8000_0000, 32'd1,          32'h0000_0001, 1};
    vecs[6]  = '{3'b000, 32'h8000_0000, 32'd31,         32'h0000_0001, 31};
    vecs[7]  = '{3'b010, 32'h1234_5678, 32'd4,          32'h2345_6780, 4};
    vecs[8]  = '{3'b100, 32'h1234_5678, 32'd8,          32'h3456_7812, 8};
    vecs[9]  = '{3'b011, 32'h1234_5678, 32'd36,         32'h8123_4567, 4};
    vecs[10] = '{3'b101, 32'hDEAD_BEEF, 32'd7,          32'hDEAD_BEEF, 0};
    vecs[11] = '{3'b001, 32'h7FFF_FFFF, 32'h0000_0020,  32'h0000_0000, 32};
    vecs[12] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFE0,  32'h0000_0000, 32};

    clr = 1'b1;
    bus.start = 1'b0;
    bus.op = 3'b000;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",   32'(bus.busy), 32'd0);
    check("reset_done",   32'(bus.done), 32'd0);
    check("reset_result", bus.result,    32'd0);
    clr = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(cyc, ovl);
      check("busy_cycles", 32'(cyc), 32'(vecs[i].n));
      check("no_overlap",  32'(ovl), 32'd0);
      check("done_pulse",  32'(bus.done), 32'd1);
      check("result",      bus.result, vecs[i].exp);
      $display("vec %0d op=%0d A=%h B=%h busy=%0d result=%h", i, vecs[i].op,
               vecs[i].a, vecs[i].b, cyc, bus.result);
      tick();
      check("done_drop", 32'(bus.done), 32'd0);
      check("held",      bus.result, vecs[i].exp);
    end

    // start re-pulsed while busy must not disturb the running op
    launch(3'b010, 32'h0000_0001, 32'd10);
    tick();
    tick();
    bus.op = 3'b100; bus.A = 32'h0000_FFFF; bus.B = 32'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(cyc, ovl);
    check("ignore_busy_cycles", 32'(cyc), 32'd7);
    check("ignore_busy_result", bus.result, 32'h0000_0400);
    $display("ignore-start seq: remaining busy=%0d result=%h", cyc, bus.result);
    tick();

    // start held in DONE chains the next op with no idle gap
    launch(3'b000, 32'h0000_0080, 32'd2);
    wait_done(cyc, ovl);
    check("b2b_first_done",   32'(bus.done), 32'd1);
    check("b2b_first_result", bus.result, 32'h0000_0020);
    launch(3'b100, 32'h8000_0000, 32'd1);
    check("b2b_busy_now", 32'(bus.busy), 32'd1);
    check("b2b_done_low", 32'(bus.done), 32'd0);
    wait_done(cyc, ovl);
    check("b2b_second_cycles", 32'(cyc), 32'd1);
    check("b2b_second_result", bus.result, 32'h0000_0001);
    $display("back-to-back seq: second busy=%0d result=%h", cyc, bus.result);
    tick();

    // asynchronous clear mid-run, observed before any further edge
    launch(3'b010, 32'h0000_0001, 32'd10);
    tick();
    tick();
    #2;
    clr = 1'b1;
    #1;
    check("clr_busy",   32'(bus.busy), 32'd0);
    check("clr_done",   32'(bus.done), 32'd0);
    check("clr_result", bus.result,    32'd0);
    tick();
    clr = 1'b0;
    tick();
    check("clr_idle", 32'(bus.busy), 32'd0);
    launch(3'b010, 32'h0000_0003, 32'd10);
    wait_done(cyc, ovl);
    check("post_clr_cycles", 32'(cyc), 32'd10);
    check("post_clr_result", bus.result, 32'h0000_0C00);
    $display("clear seq: post-clear busy=%0d result=%h", cyc, bus.result);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
